// File: rtl/tx_pkg.sv
// Shared transmitter definitions: coding-rate codes, encoder generator defaults
// and the convolutional encoder FSM state encoding.
package tx_pkg;

  typedef enum logic [1:0] {
    RATE_1_2 = 2'b00,
    RATE_2_3 = 2'b01,
    RATE_3_4 = 2'b10
  } rate_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } enc_state_t;

  localparam logic [6:0] G0_DEFAULT = 7'o133;
  localparam logic [6:0] G1_DEFAULT = 7'o171;

  // The reserved code 2'b11 falls back to rate 1/2.
  function automatic rate_t decode_rate(input logic [1:0] code);
    case (code)
      2'b01:   decode_rate = RATE_2_3;
      2'b10:   decode_rate = RATE_3_4;
      default: decode_rate = RATE_1_2;
    endcase
  endfunction

  function automatic logic [1:0] last_phase(input rate_t r);
    case (r)
      RATE_2_3: last_phase = 2'd1;
      RATE_3_4: last_phase = 2'd2;
      default:  last_phase = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/conv_shift_reg.sv
// Constraint-length-7 shift register producing the two mother-code bits
// for the bit currently being accepted.
module conv_shift_reg
  import tx_pkg::*;
#(
  parameter logic [6:0] G0 = G0_DEFAULT,
  parameter logic [6:0] G1 = G1_DEFAULT
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  input  logic din,
  output logic coded_a,
  output logic coded_b
);

  logic [5:0] s;
  logic [6:0] window;

  // Generator MSB is delay 0, so the window runs from the new bit down to s[5].
  assign window  = {din, s[0], s[1], s[2], s[3], s[4], s[5]};
  assign coded_a = ^(window & G0);
  assign coded_b = ^(window & G1);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      s <= '0;
    end else if (clear) begin
      s <= '0;
    end else if (enable) begin
      s <= {s[4:0], din};
    end
  end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 K=7 convolutional encoder with 802.11a puncturing to 2/3 and 3/4,
// ready/valid on both sides with a two-bit output holding buffer.
//
// state    | meaning
// ST_IDLE  | no frame active, input blocked
// ST_RUN   | accepting input bits and emitting coded bits
// ST_DRAIN | last input taken, emptying the output buffer
module conv_encoder
  import tx_pkg::*;
#(
  parameter logic [6:0] G0 = G0_DEFAULT,
  parameter logic [6:0] G1 = G1_DEFAULT
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [1:0] Rate,
  input  logic       In_Data,
  input  logic       In_Valid,
  input  logic       In_Last,
  output logic       In_Ready,
  output logic       Out_Data,
  output logic       Out_Valid,
  input  logic       Out_Ready,
  output logic       Done
);

  enc_state_t state;
  rate_t      rate_q;
  logic [1:0] phase;
  logic [1:0] obuf;
  logic [1:0] count;
  logic       done_q;

  logic       accept;
  logic       xfer;
  logic       coded_a;
  logic       coded_b;
  logic [1:0] q_bits;
  logic [1:0] q_cnt;

  conv_shift_reg #(
    .G0(G0),
    .G1(G1)
  ) u_shift_reg (
    .Clock  (Clock),
    .Reset  (Reset),
    .clear  (Start),
    .enable (accept),
    .din    (In_Data),
    .coded_a(coded_a),
    .coded_b(coded_b)
  );

  assign Out_Valid = (count != 2'd0);
  assign Out_Data  = obuf[0];
  assign Done      = done_q;
  assign In_Ready  = (state == ST_RUN) && !Start &&
                     ((count == 2'd0) || ((count == 2'd1) && Out_Ready));
  assign accept    = In_Valid && In_Ready;
  assign xfer      = Out_Valid && Out_Ready;

  // Puncturing: which coded bits survive for the current phase, head in bit 0.
  always_comb begin
    q_bits = {coded_b, coded_a};
    q_cnt  = 2'd2;
    case (rate_q)
      RATE_2_3: if (phase == 2'd1) q_cnt = 2'd1;
      RATE_3_4: begin
        if (phase == 2'd1) begin
          q_cnt = 2'd1;
        end else if (phase == 2'd2) begin
          q_bits = {1'b0, coded_b};
          q_cnt  = 2'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state  <= ST_IDLE;
      rate_q <= RATE_1_2;
      phase  <= 2'd0;
      obuf   <= 2'b00;
      count  <= 2'd0;
      done_q <= 1'b0;
    end else if (Start) begin
      state  <= ST_RUN;
      rate_q <= decode_rate(Rate);
      phase  <= 2'd0;
      obuf   <= 2'b00;
      count  <= 2'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        // In_Ready guarantees the buffer is empty after this cycle's transfer.
        obuf  <= q_bits;
        count <= q_cnt;
        phase <= (phase == last_phase(rate_q)) ? 2'd0 : phase + 2'd1;
        if (In_Last) state <= ST_DRAIN;
      end else if (xfer) begin
        obuf  <= {1'b0, obuf[1]};
        count <= count - 2'd1;
        if (state == ST_DRAIN && count == 2'd1) begin
          state  <= ST_IDLE;
          done_q <= 1'b1;
        end
      end
    end
  end

endmodule
